bram_flush_sequencer: RTL and testbench



---
 rtl/bram_flush_pkg.sv | 10 +
 rtl/bram_flush_addr_gen.sv | 23 ++
 rtl/bram_flush_sequencer.sv | 88 ++++++++
 tb/tb_bram_flush_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_flush_pkg.sv
// bram_flush_pkg: shared state encoding, default widths and depth helper for the BRAM flush sequencer
package bram_flush_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 36;
  localparam int FLUSH_STRIDE_DEF = 1;
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/bram_flush_addr_gen.sv
// bram_flush_addr_gen: strided flush address counter with carry-out detection of the last write
module bram_flush_addr_gen
  import bram_flush_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FLUSH_STRIDE = FLUSH_STRIDE_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH + 1)'(FLUSH_STRIDE);
  logic [ADDR_WIDTH:0] sum;
  assign sum  = {1'b0, addr} + STEP;
  assign last = sum[ADDR_WIDTH];
  // counter sits at 0 while idle so every flush starts from address 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) addr <= '0;
    else addr <= clear ? '0 : step ? sum[ADDR_WIDTH-1:0] : addr;
endmodule

// File: rtl/bram_flush_sequencer.sv
// bram_flush_sequencer: walks all BRAM addresses writing the flush word, else registers user writes through; BRAM_FLUSH_PROGRESS_EN adds flush_count
module bram_flush_sequencer
  import bram_flush_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FLUSH_STRIDE = FLUSH_STRIDE_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_const,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  input  logic                  user_wen,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_wdata,
  output logic                  user_stall,
  output logic                  bram_wen,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata
`ifdef BRAM_FLUSH_PROGRESS_EN
  ,
  output logic [ADDR_WIDTH:0]   flush_count
`endif
);
  state_t state;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic last;
  bram_flush_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .FLUSH_STRIDE(FLUSH_STRIDE)
  ) u_addr_gen (
    .clk(clk),
    .reset_n(reset_n),
    .clear(state == IDLE),
    .step(state == FLUSH),
    .addr(gen_addr),
    .last(last)
  );
  // FSM and registered BRAM port mux; user write still wins the request cycle, dropped writes raise user_stall
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      user_stall <= 1'b0;
      bram_wen   <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          bram_wen   <= user_wen;
          bram_addr  <= user_addr;
          bram_wdata <= user_wdata;
          user_stall <= 1'b0;
          if (flush_req) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          bram_wen   <= 1'b1;
          bram_addr  <= gen_addr;
          bram_wdata <= {DATA_WIDTH{flush_const}};
          user_stall <= user_wen;
          if (last) state <= DONE;
        end
        DONE: begin
          bram_wen   <= 1'b0;
          flush_busy <= 1'b0;
          flush_done <= 1'b1;
          user_stall <= user_wen;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef BRAM_FLUSH_PROGRESS_EN
  // progress counter: cleared on flush entry, one per issued flush write, held afterwards
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) flush_count <= '0;
    else if (state == IDLE && flush_req) flush_count <= '0;
    else if (state == FLUSH) flush_count <= flush_count + 1'b1;
`endif
endmodule

// File: tb/tb_bram_flush_sequencer.sv
// tb_bram_flush_sequencer: vector table, directed flush/collision/reset sequences and random traffic against a queue-based model
module tb_bram_flush_sequencer;
  localparam int AW = 10;
  localparam int DW = 36;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, reset_n = 1'b0, flush_const = 1'b0, flush_req = 1'b0, user_wen = 1'b0;
  logic [AW-1:0] user_addr = '0;
  logic [DW-1:0] user_wdata = '0;
  logic flush_busy, flush_done, user_stall, bram_wen;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic busy3, done3, stall3, wen3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] wdata3;
`ifdef BRAM_FLUSH_PROGRESS_EN
  logic [AW:0] flush_count, count3;
`endif
  always #5 clk = ~clk;

  bram_flush_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_STRIDE(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush_const(flush_const), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .user_wen(user_wen),
    .user_addr(user_addr), .user_wdata(user_wdata), .user_stall(user_stall),
    .bram_wen(bram_wen), .bram_addr(bram_addr), .bram_wdata(bram_wdata)
`ifdef BRAM_FLUSH_PROGRESS_EN
    , .flush_count(flush_count)
`endif
  );
  bram_flush_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_STRIDE(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .flush_const(flush_const), .flush_req(flush_req),
    .flush_busy(busy3), .flush_done(done3), .user_wen(user_wen),
    .user_addr(user_addr), .user_wdata(user_wdata), .user_stall(stall3),
    .bram_wen(wen3), .bram_addr(addr3), .bram_wdata(wdata3)
`ifdef BRAM_FLUSH_PROGRESS_EN
    , .flush_count(count3)
`endif
  );

  int checks = 0, errors = 0;
  int m_mode;
  int m_q[$];
  logic e_wen, e_busy, e_done, e_stall;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int e_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    {e_wen, e_busy, e_done, e_stall} = '0;
    e_addr = '0;
    e_wdata = '0;
    e_cnt = 0;
  endtask

  // model: a flush is the list of addresses 0, S, 2S, ... below depth, consumed one per cycle, then one done cycle
  task automatic model_step();
    e_done = 1'b0;
    if (m_mode == 0) begin
      e_wen = user_wen;
      e_addr = user_addr;
      e_wdata = user_wdata;
      e_stall = 1'b0;
      if (flush_req) begin
        for (int a = 0; a < DEPTH; a += 1) m_q.push_back(a);
        m_mode = 1;
        e_busy = 1'b1;
        e_cnt = 0;
      end
    end else if (m_mode == 1) begin
      e_wen = 1'b1;
      e_addr = AW'(m_q.pop_front());
      e_wdata = {DW{flush_const}};
      e_stall = user_wen;
      e_cnt++;
      if (m_q.size() == 0) m_mode = 2;
    end else begin
      e_wen = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b1;
      e_stall = user_wen;
      m_mode = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", {bram_wen, bram_addr, bram_wdata, flush_busy, flush_done, user_stall},
          {e_wen, e_addr, e_wdata, e_busy, e_done, e_stall});
`ifdef BRAM_FLUSH_PROGRESS_EN
    check("flush_count", 64'(flush_count), 64'(e_cnt));
`endif
  endtask

  typedef struct {
    logic wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic x_wen;
    logic [AW-1:0] x_a;
    logic [DW-1:0] x_d;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int w3[$];
    int done_at, done3_at, ndone, bad;
    tbl[0] = '{1'b1, 10'd5, 36'h3_DEAD_BEEF, 1'b1, 10'd5, 36'h3_DEAD_BEEF};
    tbl[1] = '{1'b0, 10'd7, 36'h0_1234_5678, 1'b0, 10'd7, 36'h0_1234_5678};
    tbl[2] = '{1'b1, 10'd1023, 36'hF_FFFF_FFFF, 1'b1, 10'd1023, 36'hF_FFFF_FFFF};
    tbl[3] = '{1'b1, 10'd0, 36'h0, 1'b1, 10'd0, 36'h0};
    tbl[4] = '{1'b1, 10'd512, 36'hA_5A5A_5A5A, 1'b1, 10'd512, 36'hA_5A5A_5A5A};
    tbl[5] = '{1'b0, 10'd3, 36'h5_0000_0001, 1'b0, 10'd3, 36'h5_0000_0001};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bram_wen, bram_addr, bram_wdata, flush_busy, flush_done, user_stall}, 0);
`ifdef BRAM_FLUSH_PROGRESS_EN
    check("reset_count", 64'(flush_count), 0);
`endif
    reset_n = 1'b1;
    foreach (tbl[i]) begin
      user_wen = tbl[i].wen;
      user_addr = tbl[i].a;
      user_wdata = tbl[i].d;
      step();
      check("tbl_wen", bram_wen, tbl[i].x_wen);
      check("tbl_addr", bram_addr, tbl[i].x_a);
      check("tbl_data", bram_wdata, tbl[i].x_d);
      check("tbl_stall", user_stall, 0);
    end
    user_wen = 1'b1;
    user_addr = 10'd5;
    user_wdata = 36'h3_DEAD_BEEF;
    flush_req = 1'b1;
    done_at = -1;
    done3_at = -1;
    ndone = 0;
    for (int k = 1; k <= 1032; k++) begin
      step();
      if (k == 1) begin
        check("collision_wen", bram_wen, 1);
        check("collision_addr", bram_addr, 5);
        check("collision_data", bram_wdata, 36'h3_DEAD_BEEF);
      end
      if (k == 4) begin
        check("drop_stall", user_stall, 1);
        check("drop_addr", bram_addr, 2);
      end
      if (k == 5) check("stall_one_cycle", user_stall, 0);
      if (k >= 2 && wen3) w3.push_back(int'(addr3));
      if (flush_done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (done3 && done3_at < 0) done3_at = k;
      if (k == 1) begin
        flush_req = 1'b0;
        user_wen = 1'b0;
      end
      if (k == 3) begin
        user_wen = 1'b1;
        user_addr = 10'd9;
      end
      if (k == 4) user_wen = 1'b0;
    end
    check("done_cycle", 64'(done_at), 1026);
    check("done_pulses", 64'(ndone), 1);
    check("stride3_done_cycle", 64'(done3_at), 344);
    check("stride3_writes", 64'(w3.size()), 342);
    check("stride3_last", 64'(w3[w3.size()-1]), 1023);
    bad = 0;
    foreach (w3[i]) if (w3[i] != 3 * i) bad++;
    check("stride3_addrs", 64'(bad), 0);
`ifdef BRAM_FLUSH_PROGRESS_EN
    check("count_hold", 64'(flush_count), 1024);
`endif
    flush_const = 1'b1;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (100) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_wen", bram_wen, 0);
    check("async_rst_busy", flush_busy, 0);
    check("async_rst_done", flush_done, 0);
    check("async_rst_addr", bram_addr, 0);
`ifdef BRAM_FLUSH_PROGRESS_EN
    check("async_rst_count", 64'(flush_count), 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    check("restart_wen", bram_wen, 1);
    check("restart_addr", bram_addr, 0);
    for (int i = 0; i < 4000; i++) begin
      user_wen = 1'($urandom_range(0, 1));
      user_addr = AW'($urandom);
      user_wdata = DW'({$urandom, $urandom});
      flush_const = 1'($urandom_range(0, 1));
      flush_req = ($urandom_range(0, 63) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
